// File: rtl/tick_period_monitor.sv
// tick_period_monitor: resynchronizes a slow square-wave tick, measures its
// period in system clocks, checks it against a window and flags lock/missing.
module tick_period_monitor #(
   parameter int unsigned CW         = 24,
   parameter int unsigned EXP_PERIOD = 10_000_000,
   parameter int unsigned TOL        = 1000,
   parameter int unsigned LOCK_CNT   = 3
) (
   input  logic          clk_100MHz,
   input  logic          rst_n,
   input  logic          tick_in,
   output logic [CW-1:0] period,
   output logic          period_valid,
   output logic          in_range,
   output logic          lock,
   output logic          missing
);

   localparam int unsigned GW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);

   // Window bounds and timeout in CW+1 bits; lower bound clamps at 0 when TOL > EXP_PERIOD.
   localparam logic [CW:0]   LO_B    = (EXP_PERIOD > TOL) ? (CW+1)'(EXP_PERIOD - TOL) : '0;
   localparam logic [CW:0]   HI_B    = (CW+1)'(EXP_PERIOD + TOL);
   localparam logic [CW:0]   TMO_B   = (CW+1)'(EXP_PERIOD + TOL + 1);
   localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
   localparam logic [GW-1:0] LOCK_V  = GW'(LOCK_CNT);

   typedef enum logic {
      ACQUIRE = 1'b0,
      MEASURE = 1'b1
   } state_e;

   state_e        state_q, state_d;
   logic          s1_q, s2_q, prev_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [GW-1:0] good_q, good_d;
   logic [CW-1:0] period_q, period_d;
   logic          pv_q, pv_d;
   logic          in_range_q, in_range_d;
   logic          lock_q, lock_d;
   logic          missing_q, missing_d;

   logic          rise_c;
   logic [CW:0]   cnt_p1_c;
   logic          win_c;

   assign rise_c   = s2_q & ~prev_q;
   assign cnt_p1_c = {1'b0, cnt_q} + (CW+1)'(1);
   assign win_c    = (cnt_p1_c >= LO_B) && (cnt_p1_c <= HI_B);

   // Two-flop synchronizer plus edge-detect history.
   always_ff @(posedge clk_100MHz) begin
      if (rst_n) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         s1_q   <= tick_in;
         s2_q   <= s1_q;
         prev_q <= s2_q;
      end
   end

   // FSM state register.
   always_ff @(posedge clk_100MHz) begin
      if (rst_n) state_q <= ACQUIRE;
      else       state_q <= state_d;
   end

   // Measurement datapath registers.
   always_ff @(posedge clk_100MHz) begin
      if (rst_n) begin
         cnt_q      <= '0;
         good_q     <= '0;
         period_q   <= '0;
         pv_q       <= 1'b0;
         in_range_q <= 1'b0;
         lock_q     <= 1'b0;
         missing_q  <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         good_q     <= good_d;
         period_q   <= period_d;
         pv_q       <= pv_d;
         in_range_q <= in_range_d;
         lock_q     <= lock_d;
         missing_q  <= missing_d;
      end
   end

   // Next-state and output logic; a rise always beats a simultaneous timeout.
   always_comb begin
      state_d    = state_q;
      cnt_d      = rise_c ? '0 : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1));
      good_d     = good_q;
      period_d   = period_q;
      pv_d       = 1'b0;
      in_range_d = in_range_q;
      lock_d     = lock_q;
      missing_d  = missing_q;

      case (state_q)
         ACQUIRE: begin
            if (rise_c) begin
               state_d   = MEASURE;
               missing_d = 1'b0;
            end
         end
         MEASURE: begin
            if (rise_c) begin
               period_d   = CW'(cnt_p1_c);
               pv_d       = 1'b1;
               in_range_d = win_c;
               if (win_c) good_d = (good_q == LOCK_V) ? good_q : good_q + GW'(1);
               else       good_d = '0;
               lock_d     = (good_d == LOCK_V);
            end else if (cnt_p1_c == TMO_B) begin
               missing_d  = 1'b1;
               lock_d     = 1'b0;
               good_d     = '0;
               in_range_d = 1'b0;
               state_d    = ACQUIRE;
            end
         end
         default: state_d = ACQUIRE;
      endcase
   end

   assign period       = period_q;
   assign period_valid = pv_q;
   assign in_range     = in_range_q;
   assign lock         = lock_q;
   assign missing      = missing_q;

endmodule

// File: doc/tick_period_monitor.md
# tick_period_monitor

Checks a slow square-wave tick, such as the 10 Hz output of the divider, inside the 100 MHz domain. It resynchronizes the tick, detects rising edges and measures the period in system clocks. Each period is compared against an expected window. The block reports the measured period, an in-range flag, a lock indication after consecutive good periods, and a missing-tick alarm. It is the consumer/checker end of the slow-clock interface.

## Interface
Parameters:
- CW, 24: counter and period width; must satisfy EXP_PERIOD+TOL+1 < 2^CW
- EXP_PERIOD, 10_000_000: expected tick period in clk_100MHz cycles (100 MHz / 10 Hz)
- TOL, 1000: allowed deviation, inclusive, in cycles
- LOCK_CNT, 3: consecutive in-range periods required for lock (≥1)

Ports:
- clk_100MHz  input  1  system clock; all logic on its rising edge
- rst_n  input  1  reset, synchronous and active-high despite the name
- tick_in  input  1  asynchronous slow square wave under test
- period  output  CW  last measured period in cycles
- period_valid  output  1  one-cycle pulse when period updates
- in_range  output  1  last measured period within EXP_PERIOD±TOL
- lock  output  1  LOCK_CNT consecutive in-range periods seen
- missing  output  1  no rising edge within EXP_PERIOD+TOL+1 cycles; sticky until next edge

## Operation
- Synchronizer: s1 ← tick_in, s2 ← s1, prev ← s2. `rise = s2 & ~prev`. All three flops reset to 0.
- Counter cnt: cleared to 0 in any cycle where rise is true. Otherwise cnt increments, saturating at 2^CW−1.
- States: ACQUIRE (reset state, no valid reference edge) and MEASURE.
- ACQUIRE, rise: go to MEASURE, cnt←0, clear missing. No period_valid, and period/in_range are unchanged.
- MEASURE, rise:
  - period ← cnt+1, period_valid ← 1.
  - in_range ← (EXP_PERIOD−TOL ≤ cnt+1 ≤ EXP_PERIOD+TOL).
  - If in range, good_cnt increments, saturating at LOCK_CNT. Otherwise good_cnt ← 0.
  - lock ← (new good_cnt == LOCK_CNT).
- MEASURE, no rise, cnt+1 == EXP_PERIOD+TOL+1:
  - missing ← 1, lock ← 0, good_cnt ← 0, in_range ← 0.
  - Go to ACQUIRE. period is retained.
- Rise and timeout in the same cycle: rise wins. The period is reported as EXP_PERIOD+TOL+1, which is out of range, so lock drops.
- Saturation arithmetic is unsigned. The range compare uses CW+1 bits so that EXP_PERIOD−TOL cannot underflow when TOL > EXP_PERIOD; in that case the lower bound is 0.

## Timing
- Reset (rst_n=1 sampled at a clock edge): state=ACQUIRE, cnt=0, good_cnt=0, s1/s2/prev=0, period=0, period_valid=0, in_range=0, lock=0, missing=0.
- Reset mid-operation discards all history. The next rise only re-arms the counter.
- If tick_in is already high at reset release, one rise occurs 2 cycles later. It is treated as the ACQUIRE reference edge.
- Latency: tick_in sampled high at edge k → rise true during the cycle after edge k+1 → outputs updated at edge k+2.
- Rise processed in cycle a: period_valid is high exactly in cycle a+1, and period/in_range/lock are valid from a+1.
- Consecutive rises processed in cycles a and b give period = b−a.
- With no further rise after cycle a, missing is 1 from cycle a+EXP_PERIOD+TOL+2.
- missing clears in the cycle after the next rise is processed.
- period_valid never asserts for the first edge after reset or after a missing event.

## Test plan
Use CW=8, EXP_PERIOD=100, TOL=2, LOCK_CNT=3.
- **Nominal:** square wave, period 100 cycles, 5 rises → no pulse on the first rise; 4 pulses with period=100, in_range=1; lock=1 from the pulse of the 4th rise.
- **Edges of window:** periods 98, 102, 103, 97 → in_range 1, 1, 0, 0; lock clears on the 103 measurement.
- **Missing:** lock established, then tick_in held low → missing=1 exactly 104 cycles after the last rise-processing cycle, lock=0. The next rise clears missing with no period_valid. The following rise at +100 gives period=100.
- **Simultaneous:** the rise is processed exactly at the timeout cycle (period 103) → period_valid=1, period=103, in_range=0, missing stays 0.
- **Reset mid-operation:** rst_n=1 for 1 cycle while locked → all outputs 0 next cycle. The first rise after reset produces no period_valid.
- **Reset with input high:** tick_in=1 through reset release → one rise, ACQUIRE→MEASURE, no period_valid. The next rise at +100 reports period=100.
